// File: rtl/cache_axi_refill_if.sv
// AXI4 bus bundle between a cache refill engine and the system bus.
// master : refill engine side (drives AR/AW/W, R-ready, B-ready)
// slave  : bus side (drives ready signals, R data, B response)
interface cache_axi_refill_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;

    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              rlast;
    logic              rready;

    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;

    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic              bvalid;
    logic              bready;

    modport master (
        output araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rvalid, rlast,
        output rready,
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bvalid,
        output bready
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rvalid, rlast,
        input  rready,
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bvalid,
        input  bready
    );
endinterface

// File: rtl/cache_axi_refill.sv
// Cache line refill / dirty-victim write-back engine.
// On a miss, optionally writes the victim line back with an 8-beat INCR burst,
// then reads the missing line with an 8-beat INCR burst and hands the assembled
// 256-bit line to the data array with a one-cycle refresh pulse.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_miss_req        start a miss sequence (sampled only when idle)
//   i_miss_addr       missing address (offset bits ignored)
//   i_wb_req          victim is dirty, sampled with i_miss_req
//   i_wb_addr         victim line address (offset bits ignored)
//   i_cacheline_old   victim line, valid the cycle after o_write_back
//   o_write_back      one-cycle victim read strobe to the data array
//   o_refresh         one-cycle line write strobe to the data array
//   o_cacheline_new   assembled refill line, word i = beat i
//   o_busy            sequence in progress
//   o_done            one-cycle completion pulse, coincident with o_refresh
//   m_axi             AXI master bundle
module cache_axi_refill (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_miss_req,
    input  logic [31:0]          i_miss_addr,
    input  logic                 i_wb_req,
    input  logic [31:0]          i_wb_addr,
    input  logic [255:0]         i_cacheline_old,
    output logic                 o_write_back,
    output logic                 o_refresh,
    output logic [255:0]         o_cacheline_new,
    output logic                 o_busy,
    output logic                 o_done,
    cache_axi_refill_if.master   m_axi
);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned BEATS  = 8;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned OFF_W  = 5;
    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BEATS - 1);
    localparam logic [7:0]       BURST_LEN  = 8'(BEATS - 1);
    localparam logic [2:0]       BURST_SIZE = 3'd2;
    localparam logic [1:0]       BURST_INCR = 2'b01;

    typedef enum logic [3:0] {
        IDLE, WB_RD, WB_CAP, WB_AW, WB_W, WB_B, RF_AR, RF_R, RF_DONE
    } state_t;

    state_t                         r_state, w_state_next;
    logic [CNT_W-1:0]               r_cnt, w_cnt_next;
    logic [ADDR_W-1:0]              r_miss_addr, w_miss_addr_next;
    logic [ADDR_W-1:0]              r_wb_addr, w_wb_addr_next;
    logic [BEATS-1:0][WORD_W-1:0]   r_wb_buf, w_wb_buf_next;
    logic [BEATS-1:0][WORD_W-1:0]   r_line, w_line_next;

    logic              r_write_back, r_refresh, r_busy;
    logic              r_arvalid, r_awvalid, r_wvalid, r_wlast, r_rready, r_bready;
    logic [WORD_W-1:0] r_wdata;

    // Next-state and datapath update; valids are registered so a handshake
    // is simply "ready while in the state that asserts valid".
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_miss_addr_next = r_miss_addr;
        w_wb_addr_next   = r_wb_addr;
        w_wb_buf_next    = r_wb_buf;
        w_line_next      = r_line;

        unique case (r_state)
            IDLE: begin
                if (i_miss_req) begin
                    w_miss_addr_next = {i_miss_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                    w_wb_addr_next   = {i_wb_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                    w_state_next     = i_wb_req ? WB_RD : RF_AR;
                end
            end
            WB_RD: w_state_next = WB_CAP;
            WB_CAP: begin
                w_wb_buf_next = i_cacheline_old;
                w_cnt_next    = '0;
                w_state_next  = WB_AW;
            end
            WB_AW: begin
                if (m_axi.awready) w_state_next = WB_W;
            end
            WB_W: begin
                if (m_axi.wready) begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_BEAT) w_state_next = WB_B;
                end
            end
            WB_B: begin
                if (m_axi.bvalid) w_state_next = RF_AR;
            end
            RF_AR: begin
                if (m_axi.arready) begin
                    w_cnt_next   = '0;
                    w_state_next = RF_R;
                end
            end
            RF_R: begin
                // Beat count alone terminates the burst; rlast is not trusted.
                if (m_axi.rvalid) begin
                    w_line_next[r_cnt] = m_axi.rdata;
                    w_cnt_next         = r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_BEAT) w_state_next = RF_DONE;
                end
            end
            RF_DONE: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State, datapath and output registers; outputs are decoded from the
    // next state so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_miss_addr  <= '0;
            r_wb_addr    <= '0;
            r_wb_buf     <= '0;
            r_line       <= '0;
            r_write_back <= 1'b0;
            r_refresh    <= 1'b0;
            r_busy       <= 1'b0;
            r_arvalid    <= 1'b0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_wlast      <= 1'b0;
            r_wdata      <= '0;
            r_rready     <= 1'b0;
            r_bready     <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_miss_addr  <= w_miss_addr_next;
            r_wb_addr    <= w_wb_addr_next;
            r_wb_buf     <= w_wb_buf_next;
            r_line       <= w_line_next;
            r_write_back <= (w_state_next == WB_RD);
            r_refresh    <= (w_state_next == RF_DONE);
            r_busy       <= (w_state_next != IDLE);
            r_arvalid    <= (w_state_next == RF_AR);
            r_awvalid    <= (w_state_next == WB_AW);
            r_wvalid     <= (w_state_next == WB_W);
            r_wlast      <= (w_state_next == WB_W) && (w_cnt_next == LAST_BEAT);
            r_wdata      <= w_wb_buf_next[w_cnt_next];
            r_rready     <= (w_state_next == RF_R);
            r_bready     <= (w_state_next == WB_B);
        end
    end

    assign o_write_back    = r_write_back;
    assign o_refresh       = r_refresh;
    assign o_done          = r_refresh;
    assign o_busy          = r_busy;
    assign o_cacheline_new = r_line;

    assign m_axi.araddr  = r_miss_addr;
    assign m_axi.arlen   = BURST_LEN;
    assign m_axi.arsize  = BURST_SIZE;
    assign m_axi.arburst = BURST_INCR;
    assign m_axi.arvalid = r_arvalid;
    assign m_axi.rready  = r_rready;
    assign m_axi.awaddr  = r_wb_addr;
    assign m_axi.awlen   = BURST_LEN;
    assign m_axi.awsize  = BURST_SIZE;
    assign m_axi.awburst = BURST_INCR;
    assign m_axi.awvalid = r_awvalid;
    assign m_axi.wdata   = r_wdata;
    assign m_axi.wstrb   = '1;
    assign m_axi.wlast   = r_wlast;
    assign m_axi.wvalid  = r_wvalid;
    assign m_axi.bready  = r_bready;

    // Line-offset bits and rlast are deliberately ignored.
    logic w_unused;
    assign w_unused = ^{i_miss_addr[OFF_W-1:0], i_wb_addr[OFF_W-1:0], m_axi.rlast};
endmodule

// File: tb/tb_cache_axi_refill.sv
// Directed bench for cache_axi_refill: a negedge bus/data-array responder logs
// every handshake, and the stimulus block compares the logs and DUT outputs
// against hand-computed values.
module tb_cache_axi_refill;
    logic         clk = 1'b0;
    logic         rst;
    logic         miss_req;
    logic [31:0]  miss_addr;
    logic         wb_req;
    logic [31:0]  wb_addr;
    logic [255:0] cacheline_old;
    logic         write_back, refresh, busy, done;
    logic [255:0] cacheline_new;

    cache_axi_refill_if bus();

    cache_axi_refill dut (
        .clk             (clk),
        .rst             (rst),
        .i_miss_req      (miss_req),
        .i_miss_addr     (miss_addr),
        .i_wb_req        (wb_req),
        .i_wb_addr       (wb_addr),
        .i_cacheline_old (cacheline_old),
        .o_write_back    (write_back),
        .o_refresh       (refresh),
        .o_cacheline_new (cacheline_new),
        .o_busy          (busy),
        .o_done          (done),
        .m_axi           (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Cycle k = clock period following edge k-1 after a request was set up.
    int n_edge = 0;
    int base   = 0;
    always @(posedge clk) n_edge <= n_edge + 1;

    // Stimulus-side configuration
    bit           cfg_wstall;
    bit           cfg_rlast;
    int           cfg_rgap;
    logic [31:0]  rbase;
    logic [255:0] wb_line;

    // Responder logs
    int           ar_cnt, aw_cnt, w_cnt, r_sent, refresh_cnt, done_run, done_run_max;
    int           wbk_cnt, wbk_cyc, refresh_cyc, aw_cyc, b_cyc, done_ne_refresh;
    int           stall_cnt, wstrb_bad, gap, cap_pend;
    int           ar_cyc [2];
    logic [31:0]  ar_addr_log, aw_addr_log, stall_wdata;
    logic [12:0]  ar_attr, aw_attr;
    logic [31:0]  wlog [8];
    logic [7:0]   wlast_mask;
    bit           stall_pend, stall_wlast;

    always @(negedge clk) begin
        int cyc;
        cyc = n_edge - base;
        if (rst) begin
            ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_sent = 0; refresh_cnt = 0;
            done_run = 0; done_run_max = 0; wbk_cnt = 0; wbk_cyc = -1;
            refresh_cyc = -1; aw_cyc = -1; b_cyc = -1; done_ne_refresh = 0;
            stall_cnt = 0; wstrb_bad = 0; gap = 0; cap_pend = 0;
            ar_cyc[0] = -1; ar_cyc[1] = -1;
            ar_addr_log = '0; aw_addr_log = '0; ar_attr = '0; aw_attr = '0;
            for (int i = 0; i < 8; i++) wlog[i] = '0;
            wlast_mask = '0; stall_pend = 0; stall_wlast = 0; stall_wdata = '0;
            bus.arready = 0; bus.awready = 0; bus.wready = 0; bus.bvalid = 0;
            bus.rvalid = 0; bus.rlast = 0; bus.rdata = '0;
            cacheline_old = {8{32'hDEAD_BEEF}};
        end else begin
            // A stalled W beat must be re-presented unchanged.
            if (stall_pend) begin
                chk("w_valid_held", bus.wvalid, 1'b1);
                chk("w_data_stable", bus.wdata, stall_wdata);
                chk("w_last_stable", bus.wlast, stall_wlast);
                stall_pend = 0;
            end

            // Data array: victim words appear the cycle after write_back.
            cacheline_old = (cap_pend == 1) ? wb_line : {8{32'hDEAD_BEEF}};
            cap_pend = 0;
            if (write_back) begin
                wbk_cnt++; wbk_cyc = cyc; cap_pend = 1;
            end

            if (refresh) begin
                if (refresh_cnt == 0) refresh_cyc = cyc;
                refresh_cnt++;
            end
            if (done) begin
                done_run++;
                if (done_run > done_run_max) done_run_max = done_run;
            end else done_run = 0;
            if (done !== refresh) done_ne_refresh++;

            bus.arready = 1;
            if (bus.arvalid) begin
                if (ar_cnt < 2) ar_cyc[ar_cnt] = cyc;
                ar_cnt++;
                ar_addr_log = bus.araddr;
                ar_attr = {bus.arburst, bus.arsize, bus.arlen};
                r_sent = 0; gap = 0;
            end

            bus.awready = 1;
            if (bus.awvalid) begin
                aw_cnt++; aw_cyc = cyc;
                aw_addr_log = bus.awaddr;
                aw_attr = {bus.awburst, bus.awsize, bus.awlen};
            end

            bus.wready = cfg_wstall ? ((cyc % 2) == 0) : 1'b1;
            if (bus.wvalid) begin
                if (bus.wready) begin
                    if (w_cnt < 8) begin
                        wlog[w_cnt] = bus.wdata;
                        wlast_mask[w_cnt] = bus.wlast;
                    end
                    if (bus.wstrb !== 4'hF) wstrb_bad++;
                    w_cnt++;
                end else begin
                    stall_pend = 1; stall_cnt++;
                    stall_wdata = bus.wdata; stall_wlast = bus.wlast;
                end
            end

            bus.bvalid = bus.bready;
            if (bus.bready) b_cyc = cyc;

            bus.rvalid = 0; bus.rlast = 0; bus.rdata = 32'hBAD0_0000;
            if (bus.rready) begin
                if (gap > 0) gap--;
                else if (r_sent < 8) begin
                    bus.rvalid = 1;
                    bus.rdata  = rbase + 32'(r_sent);
                    bus.rlast  = cfg_rlast && (r_sent == 7);
                    r_sent++;
                    gap = cfg_rgap;
                end
            end
        end
    end

    function automatic logic [255:0] mk_line(input logic [31:0] b);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = b + 32'(i);
        return l;
    endfunction

    task automatic apply_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    task automatic start_miss(input logic [31:0] ma, input logic wr, input logic [31:0] wa);
        miss_addr = ma; wb_req = wr; wb_addr = wa; miss_req = 1;
        base = n_edge;
        @(negedge clk);
        miss_req = 0; wb_req = 0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, done, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_write_back"}, write_back, 1'b0);
        chk({tag, "_refresh"}, refresh, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_arvalid"}, bus.arvalid, 1'b0);
        chk({tag, "_awvalid"}, bus.awvalid, 1'b0);
        chk({tag, "_wvalid"}, bus.wvalid, 1'b0);
        chk({tag, "_rready"}, bus.rready, 1'b0);
        chk({tag, "_bready"}, bus.bready, 1'b0);
        chk({tag, "_araddr"}, bus.araddr, 32'h0);
        chk({tag, "_awaddr"}, bus.awaddr, 32'h0);
        chk({tag, "_wdata"}, bus.wdata, 32'h0);
        chk({tag, "_line"}, cacheline_new, 256'h0);
    endtask

    localparam logic [12:0] ATTR = {2'b01, 3'd2, 8'd7};

    initial begin
        logic [255:0] line_a;
        int           n;
        rst = 1; miss_req = 0; miss_addr = '0; wb_req = 0; wb_addr = '0;
        cfg_wstall = 0; cfg_rlast = 0; cfg_rgap = 0; rbase = '0; wb_line = '0;
        repeat (2) @(negedge clk);
        chk_reset("por");
        rst = 0;
        @(negedge clk);

        // Clean miss, zero-wait slave
        rbase = 32'h100;
        start_miss(32'h1FC0_0124, 1'b0, 32'h0);
        wait_done("clean_done");
        chk("clean_ar_cnt", ar_cnt, 1);
        chk("clean_araddr", ar_addr_log, 32'h1FC0_0120);
        chk("clean_ar_attr", ar_attr, ATTR);
        chk("clean_ar_cyc", ar_cyc[0], 1);
        chk("clean_refresh_cyc", refresh_cyc, 10);
        chk("clean_refresh_cnt", refresh_cnt, 1);
        chk("clean_done_eq_refresh", done_ne_refresh, 0);
        chk("clean_line", cacheline_new, mk_line(32'h100));
        chk("clean_no_write_back", wbk_cnt, 0);
        chk("clean_no_aw", aw_cnt, 0);
        chk("clean_idle", busy, 1'b0);

        // Dirty miss, zero-wait slave
        apply_reset();
        wb_line = mk_line(32'hA0); rbase = 32'h200;
        start_miss(32'h0000_3000, 1'b1, 32'h0000_2045);
        wait_done("dirty_done");
        chk("dirty_wbk_cnt", wbk_cnt, 1);
        chk("dirty_wbk_cyc", wbk_cyc, 1);
        chk("dirty_aw_cyc", aw_cyc, 3);
        chk("dirty_aw_cnt", aw_cnt, 1);
        chk("dirty_awaddr", aw_addr_log, 32'h0000_2040);
        chk("dirty_aw_attr", aw_attr, ATTR);
        chk("dirty_w_cnt", w_cnt, 8);
        for (int i = 0; i < 8; i++) chk($sformatf("dirty_wdata%0d", i), wlog[i], 32'hA0 + 32'(i));
        chk("dirty_wlast", wlast_mask, 8'h80);
        chk("dirty_wstrb", wstrb_bad, 0);
        chk("dirty_ar_after_b", ar_cyc[0], b_cyc + 1);
        chk("dirty_araddr", ar_addr_log, 32'h0000_3000);
        chk("dirty_refresh_cyc", refresh_cyc, 22);
        chk("dirty_line", cacheline_new, mk_line(32'h200));

        // Backpressure: wready low on odd cycles, 3-cycle rvalid gaps
        apply_reset();
        cfg_wstall = 1; cfg_rgap = 3;
        wb_line = mk_line(32'hB0); rbase = 32'h300;
        start_miss(32'h0000_4440, 1'b1, 32'h0000_5560);
        wait_done("bp_done");
        chk("bp_stalls_seen", stall_cnt > 0, 1'b1);
        chk("bp_w_cnt", w_cnt, 8);
        for (int i = 0; i < 8; i++) chk($sformatf("bp_wdata%0d", i), wlog[i], 32'hB0 + 32'(i));
        chk("bp_wlast", wlast_mask, 8'h80);
        chk("bp_line", cacheline_new, mk_line(32'h300));
        chk("bp_refresh_cnt", refresh_cnt, 1);
        chk("bp_done_width", done_run_max, 1);
        cfg_wstall = 0; cfg_rgap = 0;

        // rlast present vs. absent
        apply_reset();
        cfg_rlast = 1; rbase = 32'h400;
        start_miss(32'h0000_0900, 1'b0, 32'h0);
        wait_done("rlast_on_done");
        line_a = cacheline_new;
        chk("rlast_on_line", line_a, mk_line(32'h400));
        chk("rlast_on_refresh_cyc", refresh_cyc, 10);
        chk("rlast_on_done_width", done_run_max, 1);
        apply_reset();
        cfg_rlast = 0;
        start_miss(32'h0000_0900, 1'b0, 32'h0);
        wait_done("rlast_off_done");
        chk("rlast_off_line", cacheline_new, mk_line(32'h400));
        chk("rlast_off_refresh_cyc", refresh_cyc, 10);
        chk("rlast_off_done_width", done_run_max, 1);

        // miss_req held high: one sequence per IDLE entry
        apply_reset();
        rbase = 32'h500;
        miss_addr = 32'h0000_0600; wb_req = 0; miss_req = 1;
        base = n_edge;
        n = 0;
        while (ar_cnt < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        miss_req = 0;
        n = 0;
        while (refresh_cnt < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        chk("held_refresh_cnt", refresh_cnt, 2);
        chk("held_ar_cnt", ar_cnt, 2);
        chk("held_ar_cyc0", ar_cyc[0], 1);
        chk("held_ar_cyc1", ar_cyc[1], 12);
        chk("held_idle", busy, 1'b0);

        // Reset in the middle of the write burst
        apply_reset();
        wb_line = mk_line(32'hC0); rbase = 32'h600;
        start_miss(32'h0000_7000, 1'b1, 32'h0000_8000);
        n = 0;
        while (w_cnt < 4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mid_in_wburst", bus.wvalid, 1'b1);
        rst = 1;
        @(negedge clk);
        chk_reset("mid");
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        rbase = 32'h700;
        start_miss(32'h8888_0010, 1'b0, 32'h0);
        wait_done("post_rst_done");
        chk("post_rst_araddr", ar_addr_log, 32'h8888_0000);
        chk("post_rst_refresh_cyc", refresh_cyc, 10);
        chk("post_rst_line", cacheline_new, mk_line(32'h700));
        chk("post_rst_no_wb", wbk_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cache_axi_refill.md
# cache_axi_refill

Line refill / victim write-back engine between the 2-way data cache arrays (8×32-bit words per line, 128 sets) and the AXI bus. On a miss it optionally reads the dirty victim line out of the data array and writes it back with an 8-beat AXI burst. It then fetches the missing line with an 8-beat AXI read burst, assembles it into a 256-bit line and presents it to the data array with a one-cycle `refresh` pulse. Instantiated once per cache (I and D), alongside the tag/LRU logic that raises the miss.

## Interface
- Parameters: none; line fixed at `CACHELINE_WIDTH` = 256 bits (8 words, 5-bit offset), bursts INCR, 8 beats, 4 bytes/beat.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- miss_req  in  1  level; start a miss sequence (sampled only in IDLE)
- miss_addr  in  32  missing address; offset bits ignored
- wb_req  in  1  victim line is dirty; sampled with miss_req
- wb_addr  in  32  victim line address; offset bits ignored
- cacheline_old  in  256  victim line from data array, valid the cycle after `write_back`
- write_back  out  1  one-cycle pulse: data array reads the victim way
- refresh  out  1  one-cycle pulse: data array writes `cacheline_new` into the LRU way
- cacheline_new  out  256  assembled refill line; word i = beat i
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, same cycle as `refresh`
- araddr/arlen/arsize/arburst/arvalid  out  32/8/3/2/1;  arready  in  1
- rdata  in  32;  rvalid/rlast  in  1;  rready  out  1
- awaddr/awlen/awsize/awburst/awvalid  out  32/8/3/2/1;  awready  in  1
- wdata  out  32;  wstrb  out  4;  wlast/wvalid  out  1;  wready  in  1
- bvalid  in  1;  bready  out  1

## Operation
- States: IDLE, WB_RD, WB_CAP, WB_AW, WB_W, WB_B, RF_AR, RF_R, RF_DONE.
- IDLE: on miss_req latch `{miss_addr[31:5],5'b0}` and `{wb_addr[31:5],5'b0}`; go WB_RD if wb_req, else RF_AR.
- WB_RD: write_back=1 (one cycle) → WB_CAP: latch cacheline_old into 256-bit wb buffer, clear beat counter → WB_AW.
- WB_AW: awvalid=1, awaddr=latched victim address; on awready → WB_W.
- WB_W: wvalid=1, wdata=buffer word[cnt], wstrb=4'hF, wlast=(cnt==7); cnt increments on each wvalid&wready; on handshake with cnt==7 → WB_B.
- WB_B: bready=1; on bvalid → RF_AR. bresp ignored.
- RF_AR: arvalid=1, araddr=latched miss address; on arready → RF_R, cnt=0.
- RF_R: rready=1; each rvalid beat writes rdata into cacheline_new word[cnt], cnt++. Completion on the 8th beat regardless of rlast; rresp ignored → RF_DONE.
- RF_DONE: refresh=1, done=1 for one cycle → IDLE.
- Constants: arlen=awlen=8'd7, arsize=awsize=3'd2, arburst=awburst=2'b01.
- Upstream holds the stalled request address (index) and the LRU stable from miss_req until done; this block does not drive them.
- cacheline_new holds its value until the next refill beat; not cleared between misses.
- miss_req while busy is ignored; a new sequence starts only from IDLE.

## Timing
- Reset: state IDLE; all valid/ready, write_back, refresh, done, busy = 0; cnt=0; cacheline_new and wb buffer = 0; address outputs 0.
- All outputs registered or decoded from state (Moore); no combinational path input→output.
- Clean miss, zero-wait bus: miss_req sampled at edge 0 → arvalid cycle 1 → beats cycles 2–9 → refresh/done cycle 10.
- Dirty miss: write_back cycle 1, capture cycle 2, awvalid from cycle 3; write burst, then B, then the refill as above.
- Valid signals held until handshake; payload stable while valid && !ready.
- rst mid-sequence: next cycle IDLE, all valids deasserted (bus assumed reset together).

## Test plan
- Clean miss, miss_addr=0x1FC0_0124, slave zero-wait, rdata=0x100+i → araddr=0x1FC0_0120, arlen=7, refresh cycle 10, cacheline_new word i=0x100+i, write_back never asserted.
- Dirty miss, wb_addr=0x0000_2040, cacheline_old words 0xA0..0xA7 → write_back one cycle, awaddr=0x0000_2040, wdata A0..A7, wlast on 8th beat only, refill after bvalid.
- Backpressure: wready low on odd cycles, rvalid gaps of 3 cycles → wdata stable while stalled; line still assembled in order; exactly one refresh.
- rlast asserted on beat 8 vs. missing: completion and data identical; done pulse one cycle.
- miss_req held high through a sequence → exactly one sequence per IDLE entry; second starts cycle after return to IDLE.
- rst asserted during WB_W beat 4 → next cycle all outputs at reset values, busy=0; a fresh miss then completes normally.
